// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: light codes driven by the controller and
// the request FSM state encodings used by the vehicle detector.
package tl_pkg;

  localparam logic [1:0] MAIN_GREEN  = 2'b00;
  localparam logic [1:0] MAIN_YELLOW = 2'b01;
  localparam logic [1:0] SIDE_GREEN  = 2'b10;
  localparam logic [1:0] SIDE_YELLOW = 2'b11;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] REQ    = 2'b01;
  localparam logic [1:0] SERVED = 2'b10;

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchroniser followed by a stability counter; a level change is
// accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module tl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic loop_raw,
  output logic present,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          present_q, present_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d      = loop_raw;
    s2_d      = s1_q;
    present_d = present_q;
    cnt_d     = '0;
    if (s2_q != present_q) begin
      if (cnt_q == LAST) begin
        present_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      present_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      present_q <= present_d;
      cnt_q     <= cnt_d;
    end
  end

  assign present = present_q;
  // Strobe on the edge that accepts a new arrival, aligned with present rising.
  assign rise    = present_d & ~present_q;

endmodule

// File: rtl/vehicle_detector.sv
// Side-road vehicle detector: debounced presence, held service request to the
// controller, arrival counter. TL_REQ_TIMEOUT_EN adds a sticky wait-timeout flag.
module vehicle_detector
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loop_raw,
  input  logic [1:0]       light,
  output logic             sensor,
  output logic             present,
  output logic [CNT_W-1:0] veh_count,
  output logic             req_timeout
);

  logic             rise;
  logic [1:0]       state_q, state_d;
  logic             sensor_q, sensor_d;
  logic [CNT_W-1:0] count_q, count_d;

  tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .loop_raw (loop_raw),
    .present  (present),
    .rise     (rise)
  );

  // Once requested, only a SIDE_GREEN grant ends the request; losing presence does not.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (present) state_d = REQ;
      REQ:     if (light == SIDE_GREEN) state_d = SERVED;
      SERVED:  if (light == MAIN_GREEN) state_d = present ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    sensor_d = (state_d == REQ);
    count_d  = count_q;
    if (rise && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sensor_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sensor_q <= sensor_d;
      count_q  <= count_d;
    end
  end

  assign sensor    = sensor_q;
  assign veh_count = count_q;

`ifdef TL_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (state_q == REQ) begin
      if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
      if (wait_d == WAIT_MAX) timeout_d = 1'b1;
    end else if (state_d == REQ) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign req_timeout        = 1'b0;
`endif

endmodule
